// File: rtl/cpu8080_pkg.sv
// rtl/cpu8080_pkg.sv - shared 8080 opcode constants, instruction length type and fetch states
package cpu8080_pkg;

    localparam int INSTR_W = 24;

    typedef logic [1:0] instr_len_t;

    localparam instr_len_t LEN_1 = 2'd1;
    localparam instr_len_t LEN_2 = 2'd2;
    localparam instr_len_t LEN_3 = 2'd3;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_SHLD = 8'h22;
    localparam logic [7:0] OP_LHLD = 8'h2A;
    localparam logic [7:0] OP_STA  = 8'h32;
    localparam logic [7:0] OP_LDA  = 8'h3A;
    localparam logic [7:0] OP_HLT  = 8'h76;
    localparam logic [7:0] OP_JMP  = 8'hC3;
    localparam logic [7:0] OP_RET  = 8'hC9;
    localparam logic [7:0] OP_CALL = 8'hCD;
    localparam logic [7:0] OP_OUT  = 8'hD3;
    localparam logic [7:0] OP_IN   = 8'hDB;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fa_state_t;

endpackage

// File: rtl/opcode_len.sv
// rtl/opcode_len.sv - combinational 8080 opcode to instruction length decoder
//
// Ports:
//   opcode  in  8  first byte of an instruction
//   len     out 2  instruction length in bytes, 1..3
module opcode_len
    import cpu8080_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] len
);

    always_comb begin
        len = LEN_1;
        // LXI rp, direct-address loads/stores, JMP, Jccc, CALL, Cccc
        if (((opcode & 8'hCF) == 8'h01) ||
            (opcode == OP_SHLD) || (opcode == OP_LHLD) ||
            (opcode == OP_STA)  || (opcode == OP_LDA)  ||
            (opcode == OP_JMP)  || (opcode == OP_CALL) ||
            ((opcode & 8'hC7) == 8'hC2) ||
            ((opcode & 8'hC7) == 8'hC4)) begin
            len = LEN_3;
        end
        // MVI r, immediate ALU ops (11ooo110), OUT, IN
        else if (((opcode & 8'hC7) == 8'h06) ||
                 ((opcode & 8'hC7) == 8'hC6) ||
                 (opcode == OP_OUT) || (opcode == OP_IN)) begin
            len = LEN_2;
        end
    end

endmodule

// File: rtl/fetch_align.sv
// rtl/fetch_align.sv - 8080 instruction fetch and alignment stage ahead of decode
//
// Optional HALT stop behaviour is compiled in with macro FETCH_ALIGN_HLT_STOP_EN.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   fetch_req/fetch_addr       16-bit word read request to instruction memory
//   fetch_valid/fetch_data     response, exactly one cycle after the request
//   dec_valid/dec_ready        handshake with decode
//   dec_instr/dec_len/dec_pc   aligned {opcode, byte2, byte3}, its length and address
//   redirect_valid/redirect_pc flush the queue and restart fetch
module fetch_align
    import cpu8080_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          QDEPTH   = 6
)(
    input  logic                 clk,
    input  logic                 rst,
    output logic                 fetch_req,
    output logic [15:0]          fetch_addr,
    input  logic                 fetch_valid,
    input  logic [15:0]          fetch_data,
    output logic                 dec_valid,
    input  logic                 dec_ready,
    output logic [INSTR_W-1:0]   dec_instr,
    output logic [1:0]           dec_len,
    output logic [15:0]          dec_pc,
    input  logic                 redirect_valid,
    input  logic [15:0]          redirect_pc
);

    localparam int CW = 4;
    localparam logic [CW-1:0] TWO = CW'(2);

    // Byte queue kept head-aligned: entry 0 is always the next opcode.
    logic [7:0]    q_q [QDEPTH];
    logic [7:0]    q_d [QDEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   fptr_q, fptr_d;
    logic [15:0]   hpc_q, hpc_d;
    logic          inflight_q, inflight_d;
    fa_state_t     state_q, state_d;

    logic [1:0]    head_len;
    logic [CW-1:0] head_len_w;
    logic [CW-1:0] pop_n;
    logic [CW-1:0] wr_idx;
    logic          fire;
    logic          push;
    logic          space_ok;

    opcode_len u_opcode_len (
        .opcode (q_q[0]),
        .len    (head_len)
    );

    assign head_len_w = {{(CW-2){1'b0}}, head_len};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_q[i] <= 8'h00;
            end
            count_q    <= '0;
            fptr_q     <= RESET_PC;
            hpc_q      <= RESET_PC;
            inflight_q <= 1'b0;
            state_q    <= ST_RUN;
        end else begin
            q_q        <= q_d;
            count_q    <= count_d;
            fptr_q     <= fptr_d;
            hpc_q      <= hpc_d;
            inflight_q <= inflight_d;
            state_q    <= state_d;
        end
    end

    always_comb begin
        fire   = dec_valid && dec_ready;
        push   = fetch_valid && inflight_q;
        pop_n  = fire ? head_len_w : '0;
        // Pop shifts the queue down; pushed bytes land right after what remains.
        wr_idx = count_q - pop_n;
        for (int i = 0; i < QDEPTH; i++) begin
            q_d[i] = 8'h00;
            if (i + int'(pop_n) < QDEPTH) begin
                q_d[i] = q_q[i + int'(pop_n)];
            end
            if (push && (i == int'(wr_idx))) begin
                q_d[i] = fetch_data[7:0];
            end
            if (push && (i == int'(wr_idx) + 1)) begin
                q_d[i] = fetch_data[15:8];
            end
        end
        count_d    = count_q - pop_n + (push ? TWO : '0);
        fptr_d     = fetch_req ? fptr_q + 16'd2 : fptr_q;
        hpc_d      = fire ? hpc_q + {14'b0, head_len} : hpc_q;
        inflight_d = fetch_req || (inflight_q && !fetch_valid);
`ifdef FETCH_ALIGN_HLT_STOP_EN
        state_d = state_q;
        if (fire && (q_q[0] == OP_HLT)) begin
            state_d = ST_HALT;
        end
`else
        state_d = ST_RUN;
`endif
        if (redirect_valid) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_d[i] = 8'h00;
            end
            count_d    = '0;
            fptr_d     = redirect_pc;
            hpc_d      = redirect_pc;
            inflight_d = 1'b0;
            state_d    = ST_RUN;
        end
    end

    always_comb begin
        // Reserve room for the response still in flight; a same-cycle pop is not credited.
        space_ok   = (int'(count_q) + (inflight_q ? 2 : 0)) <= (QDEPTH - 2);
        fetch_req  = !rst && !redirect_valid && (state_q == ST_RUN) && space_ok;
        fetch_addr = fptr_q;
        dec_valid  = !rst && (state_q == ST_RUN) && (count_q >= head_len_w);
        dec_len    = head_len;
        dec_pc     = hpc_q;
        dec_instr  = {q_q[0],
                      (head_len >= LEN_2) ? q_q[1] : 8'h00,
                      (head_len == LEN_3) ? q_q[2] : 8'h00};
    end

endmodule

// File: tb/tb_fetch_align.sv
// tb/tb_fetch_align.sv - directed self-checking bench for fetch_align
module tb_fetch_align;

    logic        clk;
    logic        rst;
    logic        dec_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        spur;

    logic        fetch_req, fetch_valid, dec_valid;
    logic [15:0] fetch_addr, fetch_data, dec_pc;
    logic [23:0] dec_instr;
    logic [1:0]  dec_len;
    logic        mem_valid;
    logic [15:0] mem_data;

    logic        w_fetch_req, w_fetch_valid, w_dec_valid, w_redirect_valid;
    logic [15:0] w_fetch_addr, w_fetch_data, w_dec_pc, w_redirect_pc;
    logic [23:0] w_dec_instr;
    logic [1:0]  w_dec_len;

    logic [7:0]  mem   [0:65535];
    logic [7:0]  mem_w [0:65535];

    int n_cmp  = 0;
    int n_fail = 0;

    assign fetch_valid   = mem_valid | spur;
    assign fetch_data    = spur ? 16'hFFFF : mem_data;

    fetch_align u_dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_instr(dec_instr), .dec_len(dec_len), .dec_pc(dec_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    fetch_align #(.RESET_PC(16'hFFFE), .QDEPTH(6)) u_dut_w (
        .clk(clk), .rst(rst),
        .fetch_req(w_fetch_req), .fetch_addr(w_fetch_addr),
        .fetch_valid(w_fetch_valid), .fetch_data(w_fetch_data),
        .dec_valid(w_dec_valid), .dec_ready(dec_ready),
        .dec_instr(w_dec_instr), .dec_len(w_dec_len), .dec_pc(w_dec_pc),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memories: fixed one-cycle read latency.
    always @(posedge clk) begin
        mem_valid     <= fetch_req;
        mem_data      <= {mem[fetch_addr + 16'd1], mem[fetch_addr]};
        w_fetch_valid <= w_fetch_req;
        w_fetch_data  <= {mem_w[w_fetch_addr + 16'd1], mem_w[w_fetch_addr]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_instr(input string tag, input logic [23:0] ei,
                                input logic [1:0] el, input logic [15:0] ep);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge clk);
            #1;
            if (dec_valid) ok = 1'b1;
        end
        chk({tag, "_seen"}, 32'(ok), 32'd1);
        chk({tag, "_instr"}, 32'(dec_instr), 32'(ei));
        chk({tag, "_len"}, 32'(dec_len), 32'(el));
        chk({tag, "_pc"}, 32'(dec_pc), 32'(ep));
    endtask

    initial begin
        logic [7:0] prog2 [8];
        bit         found;
        rst = 1'b1; dec_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0000;
        spur = 1'b0; w_redirect_valid = 1'b0; w_redirect_pc = 16'h0000;
        for (int a = 0; a < 65536; a++) begin
            mem[a]   = 8'h00;
            mem_w[a] = 8'h00;
        end
        prog2 = '{8'h21, 8'h34, 8'h12, 8'h3E, 8'h55, 8'hC3, 8'h00, 8'h10};
        for (int a = 0; a < 8; a++) mem[16'h0040 + a] = prog2[a];
        for (int a = 0; a < 16; a++) mem[16'h0080 + a] = 8'(8'h40 + a);
        mem[16'h0101] = 8'h3E; mem[16'h0102] = 8'h77;
        mem[16'h0200] = 8'h76;
        mem_w[16'hFFFE] = 8'hC3; mem_w[16'hFFFF] = 8'h34; mem_w[16'h0000] = 8'h12;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_fetch_req", 32'(fetch_req), 32'd0);
        chk("rst_dec_instr", 32'(dec_instr), 32'h0);
        chk("rst_dec_len", 32'(dec_len), 32'd1);
        chk("rst_dec_pc", 32'(dec_pc), 32'h0000);
        chk("w_rst_dec_pc", 32'(w_dec_pc), 32'hFFFE);

        // Zero-filled memory, one-byte NOPs
        @(negedge clk); rst = 1'b0; #1;
        chk("c0_req", 32'(fetch_req), 32'd1);
        chk("c0_addr", 32'(fetch_addr), 32'h0000);
        chk("w_c0_addr", 32'(w_fetch_addr), 32'hFFFE);
        @(negedge clk); #1;
        chk("c1_addr", 32'(fetch_addr), 32'h0002);
        chk("c1_dec_valid", 32'(dec_valid), 32'd0);
        chk("w_c1_addr", 32'(w_fetch_addr), 32'h0000);
        @(negedge clk); #1;
        chk("c2_req", 32'(fetch_req), 32'd1);
        chk("c2_addr", 32'(fetch_addr), 32'h0004);
        chk("c2_dec_valid", 32'(dec_valid), 32'd1);
        chk("c2_dec_pc", 32'(dec_pc), 32'h0000);
        chk("c2_dec_len", 32'(dec_len), 32'd1);
        chk("c2_dec_instr", 32'(dec_instr), 32'h0);
        chk("w_c2_dec_valid", 32'(w_dec_valid), 32'd0);
        @(negedge clk); #1;
        chk("c3_req", 32'(fetch_req), 32'd0);
        chk("c3_dec_pc", 32'(dec_pc), 32'h0001);
        chk("w_c3_dec_valid", 32'(w_dec_valid), 32'd1);
        chk("w_c3_instr", 32'(w_dec_instr), 32'hC33412);
        chk("w_c3_len", 32'(w_dec_len), 32'd3);
        chk("w_c3_pc", 32'(w_dec_pc), 32'hFFFE);
        @(negedge clk); #1;
        chk("c4_dec_pc", 32'(dec_pc), 32'h0002);
        chk("c4_req", 32'(fetch_req), 32'd1);
        chk("c4_addr", 32'(fetch_addr), 32'h0006);
        chk("w_c4_pc", 32'(w_dec_pc), 32'h0001);
        chk("w_c4_instr", 32'(w_dec_instr), 32'h0);
        chk("w_c4_len", 32'(w_dec_len), 32'd1);
        @(negedge clk); #1;
        chk("c5_dec_pc", 32'(dec_pc), 32'h0003);

        // Mixed-length program at 0x0040
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 16'h0040; #1;
        chk("rd40_req", 32'(fetch_req), 32'd0);
        @(negedge clk); redirect_valid = 1'b0; #1;
        chk("rd40_next_req", 32'(fetch_req), 32'd1);
        chk("rd40_next_addr", 32'(fetch_addr), 32'h0040);
        chk("rd40_dec_valid", 32'(dec_valid), 32'd0);
        expect_instr("lxi", 24'h213412, 2'd3, 16'h0040);
        expect_instr("mvi", 24'h3E5500, 2'd2, 16'h0043);
        expect_instr("jmp", 24'hC30010, 2'd3, 16'h0045);

        // Backpressure: decode stalled for 10 cycles, stray response injected
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 16'h0080; dec_ready = 1'b0;
        @(negedge clk); redirect_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            spur = (i == 5);
            #1;
            if (i >= 4) begin
                chk("stall_req", 32'(fetch_req), 32'd0);
                chk("stall_valid", 32'(dec_valid), 32'd1);
                chk("stall_pc", 32'(dec_pc), 32'h0080);
                chk("stall_instr", 32'(dec_instr), 32'h400000);
            end
        end
        @(negedge clk); spur = 1'b0; dec_ready = 1'b1; #1;
        chk("rel0_pc", 32'(dec_pc), 32'h0080);
        chk("rel0_instr", 32'(dec_instr), 32'h400000);
        for (int i = 1; i < 12; i++) begin
            expect_instr("stream", {8'(8'h40 + i), 16'h0000}, 2'd1, 16'(16'h0080 + i));
        end

        // Redirect coinciding with a returning response
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (fetch_valid) found = 1'b1;
        end
        redirect_valid = 1'b1; redirect_pc = 16'h0101; #1;
        chk("rdresp_found", 32'(found), 32'd1);
        chk("rdresp_req", 32'(fetch_req), 32'd0);
        @(negedge clk); redirect_valid = 1'b0; #1;
        chk("rdresp_next_req", 32'(fetch_req), 32'd1);
        chk("rdresp_next_addr", 32'(fetch_addr), 32'h0101);
        chk("rdresp_dec_valid", 32'(dec_valid), 32'd0);
        expect_instr("rdr0", 24'h3E7700, 2'd2, 16'h0101);
        expect_instr("rdr1", 24'h000000, 2'd1, 16'h0103);

        // HLT at 0x0200
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 16'h0200;
        @(negedge clk); redirect_valid = 1'b0;
        expect_instr("hlt", 24'h760000, 2'd1, 16'h0200);
`ifdef FETCH_ALIGN_HLT_STOP_EN
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            chk("halt_req", 32'(fetch_req), 32'd0);
            chk("halt_valid", 32'(dec_valid), 32'd0);
        end
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 16'h0000;
        @(negedge clk); redirect_valid = 1'b0; #1;
        chk("resume_req", 32'(fetch_req), 32'd1);
        chk("resume_addr", 32'(fetch_addr), 32'h0000);
`else
        expect_instr("after_hlt", 24'h000000, 2'd1, 16'h0201);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
